// File: rtl/bm_dl_fsm_ctx_scheduler.sv
// bm_dl_fsm_ctx_scheduler
// One shared "two consecutive ones" detector time-shared across N_CH serial
// streams. Each channel's detector state lives in a context register file.
// A round-robin arbiter picks one requester per cycle, and a 2-stage pipeline
// computes that channel's next state and writes it back.
module bm_dl_fsm_ctx_scheduler #(
    parameter int N_CH  = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_CH-1:0]  req_i,
    input  logic [N_CH-1:0]  w_i,
    input  logic [N_CH-1:0]  clr_i,
    output logic [N_CH-1:0]  ack_o,
    output logic             z_valid_o,
    output logic [IDX_W-1:0] z_ch_o,
    output logic             z_o,
    output logic [7:0]       hit_cnt_o
);

    typedef enum logic [1:0] {
        ST_A = 2'b00,
        ST_B = 2'b01,
        ST_C = 2'b10,
        ST_X = 2'b11
    } state_e;

    // Per-channel saved detector state
    state_e           ctx_q [N_CH];

    // Arbiter pointer: most recently granted channel
    logic [IDX_W-1:0] last_q;

    // Stage 1: granted sample waiting for its next-state computation
    logic             s1_v_q;
    logic [IDX_W-1:0] s1_ch_q;
    logic             s1_w_q;
    state_e           s1_st_q;
    state_e           s1_st_d;

    // Stage 2: result registers
    logic             z_valid_q;
    logic [IDX_W-1:0] z_ch_q;
    logic             z_q;
    logic [7:0]       hit_cnt_q;

    logic             gnt_v;
    logic [IDX_W-1:0] gnt_ch;
    logic [IDX_W-1:0] cand;
    logic [N_CH-1:0]  ack;
    state_e           ns;
    logic             wb_cancel;

    // Round-robin search starting just after the last granted channel
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        ack    = '0;
        gnt_v  = 1'b0;
        gnt_ch = '0;
        cand   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = IDX_W'((int'(last_q) + k) % N_CH);
            if (!gnt_v && req_i[cand] && !clr_i[cand]) begin
                gnt_v  = 1'b1;
                gnt_ch = cand;
            end
        end
        if (gnt_v && !rst_i) begin
            ack[gnt_ch] = 1'b1;
        end
    end

    // Shared detector next-state function for the sample in stage 1
    always_comb begin
        ns = ST_A;
        case (s1_st_q)
            ST_A:       ns = s1_w_q ? ST_B : ST_A;
            ST_B, ST_C: ns = s1_w_q ? ST_C : ST_A;
            default:    ns = ST_A;
        endcase
    end

    // A clear on the stage-1 channel cancels its writeback this cycle
    assign wb_cancel = clr_i[s1_ch_q];

    // Stage-1 state fetch, bypassing the not-yet-written result of the same channel
    always_comb begin
        s1_st_d = ctx_q[gnt_ch];
        if (s1_v_q && !wb_cancel && (s1_ch_q == gnt_ch)) begin
            s1_st_d = ns;
        end
    end

    // Context register file: clears win over the stage-2 writeback
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: the context file is reset because every channel must restart
        // in state A after reset; it is small enough to live in flops.
        if (rst_i) begin
            for (int i = 0; i < N_CH; i++) begin
                ctx_q[i] <= ST_A;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (clr_i[i]) begin
                    ctx_q[i] <= ST_A;
                end else if (s1_v_q && (int'(s1_ch_q) == i)) begin
                    ctx_q[i] <= ns;
                end
            end
        end
    end

    // Arbiter pointer, stage-1 capture and stage-2 result registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (rst_i) begin
            last_q    <= IDX_W'(N_CH - 1);
            s1_v_q    <= 1'b0;
            s1_ch_q   <= '0;
            s1_w_q    <= 1'b0;
            s1_st_q   <= ST_A;
            z_valid_q <= 1'b0;
            z_ch_q    <= '0;
            z_q       <= 1'b0;
            hit_cnt_q <= '0;
        end else begin
            s1_v_q <= gnt_v;
            if (gnt_v) begin
                last_q  <= gnt_ch;
                s1_ch_q <= gnt_ch;
                s1_w_q  <= w_i[gnt_ch];
                s1_st_q <= s1_st_d;
            end
            z_valid_q <= s1_v_q;
            if (s1_v_q) begin
                z_ch_q    <= s1_ch_q;
                z_q       <= (ns == ST_C);
                hit_cnt_q <= hit_cnt_q + {7'd0, (ns == ST_C)};
            end
        end
    end

    assign ack_o     = ack;
    assign z_valid_o = z_valid_q;
    assign z_ch_o    = z_ch_q;
    assign z_o       = z_q;
    assign hit_cnt_o = hit_cnt_q;

endmodule
